// File: rtl/memory_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_lsu_pkg
// Description : Shared types for the MEM-stage load/store unit: funct3 access
//               size codes, LSU FSM states and the WB control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_stage_lsu_pkg;

  // funct3 encodings of the access size; D and WU exist only when XLEN=64
  typedef enum logic [2:0] {
    MS_B  = 3'b000,
    MS_H  = 3'b001,
    MS_W  = 3'b010,
    MS_D  = 3'b011,
    MS_BU = 3'b100,
    MS_HU = 3'b101,
    MS_WU = 3'b110
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_t;

  // Write-back control carried from EX/MEM to MEM/WB untouched
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } control_type;

endpackage
`default_nettype wire

// File: rtl/memory_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_lsu_align
// Description : Combinational lane logic: byte enables, lane-replicated store
//               data, load lane extraction with sign/zero extension, and the
//               alignment / legal-size check.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_lsu_align
  import memory_stage_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [OFF_W-1:0] off_i,
  input  logic [2:0]       size_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             misaligned_o
);

  logic [XLEN-1:0]    w_shift;
  logic signed [7:0]  w_b;
  logic signed [15:0] w_h;
  logic signed [31:0] w_w;

  // Move the addressed lane down to bit 0 before extension
  assign w_shift = rdata_i >> {off_i, 3'b000};
  assign w_b     = w_shift[7:0];
  assign w_h     = w_shift[15:0];
  assign w_w     = w_shift[31:0];

  // Decode size into enables, replicated store data, extended load data and legality
  always_comb begin
    be_o         = '0;
    wdata_o      = '0;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (size_i)
      MS_B: begin
        be_o    = BE_W'(1) << off_i;
        wdata_o = {BE_W{wdata_i[7:0]}};
        rdata_o = XLEN'(w_b);
      end
      MS_BU: begin
        be_o    = BE_W'(1) << off_i;
        wdata_o = {BE_W{wdata_i[7:0]}};
        rdata_o = XLEN'(w_shift[7:0]);
      end
      MS_H: begin
        misaligned_o = off_i[0];
        be_o         = BE_W'(3) << off_i;
        wdata_o      = {(XLEN/16){wdata_i[15:0]}};
        rdata_o      = XLEN'(w_h);
      end
      MS_HU: begin
        misaligned_o = off_i[0];
        be_o         = BE_W'(3) << off_i;
        wdata_o      = {(XLEN/16){wdata_i[15:0]}};
        rdata_o      = XLEN'(w_shift[15:0]);
      end
      MS_W: begin
        misaligned_o = |off_i[1:0];
        be_o         = BE_W'(15) << off_i;
        wdata_o      = {(XLEN/32){wdata_i[31:0]}};
        rdata_o      = XLEN'(w_w);
      end
      MS_WU: begin
        if (XLEN == 64) begin
          misaligned_o = |off_i[1:0];
          be_o         = BE_W'(15) << off_i;
          wdata_o      = {(XLEN/32){wdata_i[31:0]}};
          rdata_o      = XLEN'(w_shift[31:0]);
        end else begin
          misaligned_o = 1'b1;
        end
      end
      MS_D: begin
        if (XLEN == 64) begin
          misaligned_o = |off_i;
          be_o         = '1;
          wdata_o      = wdata_i;
          rdata_o      = w_shift;
        end else begin
          misaligned_o = 1'b1;
        end
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_lsu
// Description : MEM pipeline stage with a multi-cycle load/store unit.
//               Issues valid/ready requests to data memory, waits for a
//               response (with optional timeout), and registers all results
//               into the MEM/WB register. Stalls upstream while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_lsu
  import memory_stage_lsu_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int CNT_W          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         mem_size,
  input  logic [XLEN-1:0]    memory_data,
  input  control_type        control_in,
  input  logic [4:0]         rd_in,
  input  logic [XLEN-1:0]    pc,
  output logic               stall_out,
  output logic               dmem_req_valid,
  input  logic               dmem_req_ready,
  output logic [XLEN-1:0]    dmem_addr,
  output logic               dmem_we,
  output logic [XLEN/8-1:0]  dmem_be,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_rsp_valid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               valid_out,
  output logic [XLEN-1:0]    memory_bypass,
  output logic [XLEN-1:0]    memory_output,
  output control_type        control_out,
  output logic [4:0]         rd_out,
  output logic [XLEN-1:0]    pc_out,
  output logic               misaligned_out,
  output logic               bus_error_out
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;

  logic [XLEN-1:0]   addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [XLEN-1:0]   wdata_q;

  logic              valid_q;
  logic [XLEN-1:0]   bypass_q;
  logic [XLEN-1:0]   mout_q;
  control_type       ctrl_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   pc_q;
  logic              mis_q;
  logic              berr_q;

  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_rdata;
  logic              w_bad;
  logic              w_mem_op;
  logic              w_load;
  logic              w_tmo_hit;
  logic              w_accept;
  logic              w_done;
  logic              w_tmo;
  logic              w_stall;
  logic              w_req_valid;

  memory_stage_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .off_i        (alu_result[OFF_W-1:0]),
    .size_i       (mem_size),
    .wdata_i      (memory_data),
    .rdata_i      (dmem_rdata),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .rdata_o      (w_rdata),
    .misaligned_o (w_bad)
  );

  assign w_mem_op  = MemRead | MemWrite;
  assign w_load    = MemRead & ~MemWrite;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state, handshake and completion decode; stall drops on the result edge
  always_comb begin
    state_d     = state_q;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_stall     = 1'b0;
    w_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (w_mem_op && !w_bad) begin
            w_accept = 1'b1;
            w_stall  = 1'b1;
            state_d  = REQ;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      REQ: begin
        w_req_valid = 1'b1;
        if (w_tmo_hit) begin
          w_done  = 1'b1;
          w_tmo   = 1'b1;
          state_d = IDLE;
        end else begin
          w_stall = 1'b1;
          if (dmem_req_ready) state_d = RSP;
        end
      end
      RSP: begin
        // A response arriving on the terminal count still completes normally
        if (dmem_rsp_valid) begin
          w_done  = 1'b1;
          state_d = IDLE;
        end else if (w_tmo_hit) begin
          w_done  = 1'b1;
          w_tmo   = 1'b1;
          state_d = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Timeout counter: cleared when a request is accepted, counts every busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (w_accept) begin
      cnt_q <= '0;
    end else if ((state_q != IDLE) && (TIMEOUT_CYCLES != 0)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Request latch: address/enables/data stay stable for the whole REQ phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (w_accept) begin
      addr_q  <= {alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      we_q    <= MemWrite;
      be_q    <= w_be;
      wdata_q <= w_wdata;
    end
  end

  // MEM/WB register: written on completion, valid and flags pulse for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      bypass_q <= '0;
      mout_q   <= '0;
      ctrl_q   <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      valid_q <= w_done;
      mis_q   <= w_done & (state_q == IDLE) & w_mem_op & w_bad;
      berr_q  <= w_tmo;
      if (w_done) begin
        bypass_q <= alu_result;
        mout_q   <= ((state_q == RSP) && dmem_rsp_valid && w_load) ? w_rdata : '0;
        ctrl_q   <= control_in;
        rd_q     <= rd_in;
        pc_q     <= pc;
      end
    end
  end

  // Stall is forced low while reset is asserted, even with a memory op waiting
  assign stall_out      = w_stall & rst;
  assign dmem_req_valid = w_req_valid;
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;

  assign valid_out      = valid_q;
  assign memory_bypass  = bypass_q;
  assign memory_output  = mout_q;
  assign control_out    = ctrl_q;
  assign rd_out         = rd_q;
  assign pc_out         = pc_q;
  assign misaligned_out = mis_q;
  assign bus_error_out  = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage_lsu
// Description : Directed self-checking bench for memory_stage_lsu (XLEN=32,
//               TIMEOUT_CYCLES=4) with a queue scoreboard of MEM/WB results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage_lsu;
  import memory_stage_lsu_pkg::*;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic [XLEN-1:0]   alu_result;
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        mem_size;
  logic [XLEN-1:0]   memory_data;
  control_type       control_in;
  logic [4:0]        rd_in;
  logic [XLEN-1:0]   pc;
  logic              stall_out;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [XLEN-1:0]   dmem_addr;
  logic              dmem_we;
  logic [XLEN/8-1:0] dmem_be;
  logic [XLEN-1:0]   dmem_wdata;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rdata;
  logic              valid_out;
  logic [XLEN-1:0]   memory_bypass;
  logic [XLEN-1:0]   memory_output;
  control_type       control_out;
  logic [4:0]        rd_out;
  logic [XLEN-1:0]   pc_out;
  logic              misaligned_out;
  logic              bus_error_out;

  always #5 clk = ~clk;

  memory_stage_lsu #(
    .XLEN           (XLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .alu_result     (alu_result),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_size       (mem_size),
    .memory_data    (memory_data),
    .control_in     (control_in),
    .rd_in          (rd_in),
    .pc             (pc),
    .stall_out      (stall_out),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .valid_out      (valid_out),
    .memory_bypass  (memory_bypass),
    .memory_output  (memory_output),
    .control_out    (control_out),
    .rd_out         (rd_out),
    .pc_out         (pc_out),
    .misaligned_out (misaligned_out),
    .bus_error_out  (bus_error_out)
  );

  typedef struct {
    logic [31:0] bypass;
    logic [31:0] mout;
    logic [31:0] pc;
    logic [4:0]  rd;
    control_type ctrl;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   op_idx = 0;
  bit   late_rsp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd_, input logic wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_in    = 1'b1;
    MemRead     = rd_;
    MemWrite    = wr;
    mem_size    = sz;
    alu_result  = a;
    memory_data = wd;
    rd_in       = 5'(op_idx + 1);
    pc          = 32'h1000 + 32'(op_idx * 4);
    control_in  = '{reg_write: ~wr, mem_to_reg: rd_};
    op_idx++;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "/sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "/bypass"},  64'(memory_bypass),  64'(e.bypass));
      chk({tag, "/mout"},    64'(memory_output),  64'(e.mout));
      chk({tag, "/rd"},      64'(rd_out),         64'(e.rd));
      chk({tag, "/pc"},      64'(pc_out),         64'(e.pc));
      chk({tag, "/ctrl"},    64'(control_out),    64'(e.ctrl));
      chk({tag, "/misalig"}, 64'(misaligned_out), 64'(e.mis));
      chk({tag, "/buserr"},  64'(bus_error_out),  64'(e.berr));
    end
  endtask

  // One instruction from drive to MEM/WB, acting as the data memory meanwhile
  task automatic run_op(input string tag, input logic rd_, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ready_wait, input bit respond,
                        input int exp_lat, input int exp_stall, input bit exp_req,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_mout, input bit exp_mis, input bit exp_berr);
    exp_t e;
    int cycles = 0, stalls = 0, waits = 0;
    bit acc_prev = 0, acc_any = 0, seen_req = 0, got = 0;
    logic [31:0] r_addr = '0, r_wd = '0;
    logic [3:0]  r_be = '0;
    logic        r_we = 1'b0;
    drive(rd_, wr, sz, a, wd);
    e.bypass = a; e.mout = exp_mout; e.pc = pc; e.rd = rd_in;
    e.ctrl = control_in; e.mis = exp_mis; e.berr = exp_berr;
    sb.push_back(e);
    while (!got && cycles < 20) begin
      dmem_rsp_valid = respond && acc_prev;
      dmem_rdata     = rdata;
      #1;
      if (stall_out) stalls++;
      acc_prev       = 1'b0;
      dmem_req_ready = 1'b0;
      if (dmem_req_valid) begin
        seen_req = 1'b1;
        if (waits < ready_wait) begin
          waits++;
        end else begin
          dmem_req_ready = 1'b1;
          acc_prev = 1'b1;
          acc_any  = 1'b1;
          r_addr = dmem_addr; r_be = dmem_be; r_wd = dmem_wdata; r_we = dmem_we;
        end
      end
      @(posedge clk); @(negedge clk);
      cycles++;
      if (valid_out) got = 1'b1;
    end
    chk({tag, "/latency"}, 64'(cycles),   64'(exp_lat));
    chk({tag, "/stalls"},  64'(stalls),   64'(exp_stall));
    chk({tag, "/req"},     64'(seen_req), 64'(exp_req));
    if (got) check_result(tag);
    else     sb.delete();
    if (acc_any) begin
      chk({tag, "/addr"},  64'(r_addr), 64'(a & 32'hFFFF_FFFC));
      chk({tag, "/be"},    64'(r_be),   64'(exp_be));
      chk({tag, "/wdata"}, 64'(r_wd),   64'(exp_wdata));
      chk({tag, "/we"},    64'(r_we),   64'(wr));
    end
    valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = late_rsp;
    dmem_rdata     = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk({tag, "/valid_drop"}, 64'(valid_out),      64'(0));
    chk({tag, "/berr_drop"},  64'(bus_error_out),  64'(0));
    chk({tag, "/req_idle"},   64'(dmem_req_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; valid_in = 1'b0; alu_result = '0; MemRead = 1'b0; MemWrite = 1'b0;
    mem_size = 3'b010; memory_data = '0; control_in = '0; rd_in = '0; pc = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst/valid_out", 64'(valid_out),      64'(0));
    chk("rst/stall",     64'(stall_out),      64'(0));
    chk("rst/req_valid", 64'(dmem_req_valid), 64'(0));
    chk("rst/mout",      64'(memory_output),  64'(0));
    chk("rst/berr",      64'(bus_error_out),  64'(0));
    rst = 1'b1;
    @(negedge clk);

    // tag rd wr size addr wdata rdata wait rsp | lat stall req be wdata mout mis berr
    run_op("lw",     1, 0, MS_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 3, 2, 1, 4'hF, 32'h0,        32'hDEADBEEF, 0, 0);
    run_op("lb",     1, 0, MS_B,  32'h103, 32'h0,        32'h80123456, 0, 1, 3, 2, 1, 4'h8, 32'h0,        32'hFFFFFF80, 0, 0);
    run_op("lbu",    1, 0, MS_BU, 32'h103, 32'h0,        32'h80123456, 0, 1, 3, 2, 1, 4'h8, 32'h0,        32'h00000080, 0, 0);
    run_op("lh",     1, 0, MS_H,  32'h102, 32'h0,        32'h80017F00, 0, 1, 3, 2, 1, 4'hC, 32'h0,        32'hFFFF8001, 0, 0);
    run_op("lhu",    1, 0, MS_HU, 32'h102, 32'h0,        32'h80017F00, 0, 1, 3, 2, 1, 4'hC, 32'h0,        32'h00008001, 0, 0);
    run_op("lw_wt",  1, 0, MS_W,  32'h204, 32'h0,        32'h12345678, 2, 1, 5, 4, 1, 4'hF, 32'h0,        32'h12345678, 0, 0);
    run_op("sh",     0, 1, MS_H,  32'h102, 32'hABCD1234, 32'hFFFFFFFF, 0, 1, 3, 2, 1, 4'hC, 32'h12341234, 32'h0,        0, 0);
    run_op("sb",     0, 1, MS_B,  32'h101, 32'h000000A5, 32'hFFFFFFFF, 0, 1, 3, 2, 1, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 0);
    run_op("sw",     0, 1, MS_W,  32'h104, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 3, 2, 1, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0);
    run_op("lw_mis", 1, 0, MS_W,  32'h102, 32'h0,        32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    run_op("lh_mis", 1, 0, MS_H,  32'h101, 32'h0,        32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    run_op("ld_ill", 1, 0, MS_D,  32'h100, 32'h0,        32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    run_op("sz7_ill",1, 0, 3'b111,32'h100, 32'h0,        32'h0,        0, 1, 1, 0, 0, 4'h0, 32'h0,        32'h0,        1, 0);
    run_op("add",    0, 0, MS_W,  32'h55AA, 32'h0,       32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0);
    run_op("lw_term",1, 0, MS_W,  32'h108, 32'h0,        32'hA5A50F0F, 3, 1, 6, 5, 1, 4'hF, 32'h0,        32'hA5A50F0F, 0, 0);
    late_rsp = 1'b1;
    run_op("lw_tmo", 1, 0, MS_W,  32'h200, 32'h0,        32'h0,        0, 0, 6, 5, 1, 4'hF, 32'h0,        32'h0,        0, 1);
    late_rsp = 1'b0;
    run_op("add_t",  0, 0, MS_W,  32'h0BAD, 32'h0,       32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0);

    // Reset while a load sits in RSP; the load is lost
    drive(1, 0, MS_W, 32'h300, 32'h0);
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstmid/stall",     64'(stall_out),      64'(0));
    chk("rstmid/req_valid", 64'(dmem_req_valid), 64'(0));
    chk("rstmid/valid_out", 64'(valid_out),      64'(0));
    chk("rstmid/addr",      64'(dmem_addr),      64'(0));
    chk("rstmid/be",        64'(dmem_be),        64'(0));
    chk("rstmid/pc_out",    64'(pc_out),         64'(0));
    chk("rstmid/bypass",    64'(memory_bypass),  64'(0));
    @(posedge clk); @(negedge clk);
    chk("rstmid/stall_hold", 64'(stall_out),     64'(0));
    rst = 1'b1;
    run_op("add_r",  0, 0, MS_W,  32'h7777, 32'h0,       32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0,        32'h0,        0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
